// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared constants, edit state type and modulo-60 step helper
package clock_pkg;

    localparam logic [5:0] MAX_VAL = 6'd59;

    // Defaults sized for a 50 MHz system clock
    localparam int DEF_DEBOUNCE_CYC = 50_000;
    localparam int DEF_HOLD_CYC     = 25_000_000;
    localparam int DEF_REPEAT_CYC   = 5_000_000;
    localparam int DEF_TIMEOUT_CYC  = 500_000_000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EDIT_MIN = 2'd1,
        EDIT_SEG = 2'd2
    } edit_state_t;

    // One step up or down on a 0..59 field; out-of-range inputs land back in range
    function automatic logic [5:0] step_mod60(input logic [5:0] v, input logic up);
        if (up) begin
            return (v >= MAX_VAL) ? 6'd0 : v + 6'd1;
        end else begin
            return ((v == 6'd0) || (v > MAX_VAL)) ? MAX_VAL : v - 6'd1;
        end
    endfunction

endpackage

// File: rtl/btn_cond.sv
// rtl/btn_cond.sv - push-button synchronizer, debouncer, press pulse and auto-repeat
module btn_cond
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int HOLD_CYC     = DEF_HOLD_CYC,
    parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic pulse
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int RP_MAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
    localparam int RP_W   = $clog2(RP_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [RP_W-1:0] HOLD_LAST = RP_W'(HOLD_CYC - 1);
    localparam logic [RP_W-1:0] REP_LAST  = RP_W'(REPEAT_CYC - 1);

    logic            sync1, sync2;
    logic            level, level_d;
    logic [DB_W-1:0] db_cnt;
    logic [RP_W-1:0] rep_cnt;
    logic            rep_armed;
    logic            press, held, rep_fire;

    assign press    = level & ~level_d;
    assign held     = level & level_d;
    assign rep_fire = REPEAT_EN && held &&
                      ((!rep_armed && (rep_cnt == HOLD_LAST)) ||
                       ( rep_armed && (rep_cnt == REP_LAST)));

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYC consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (sync2 == level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            level  <= sync2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Hold timer: first repeat HOLD_CYC after the press, then every REPEAT_CYC; release clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (!REPEAT_EN || !held) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (rep_fire) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b1;
        end else begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end

    // Registered one-cycle event pulse from the press edge or a repeat tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            level_d <= level;
            pulse   <= press | rep_fire;
        end
    end

endmodule

// File: rtl/time_set_editor.sv
// rtl/time_set_editor.sv - button-driven min:sec edit FSM with commit strobe and idle timeout
module time_set_editor
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int HOLD_CYC     = DEF_HOLD_CYC,
    parameter int REPEAT_CYC   = DEF_REPEAT_CYC,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [5:0] Minutos,
    input  logic [5:0] Segundos,
    output logic       setTime,
    output logic       field_sel,
    output logic [5:0] MinutosPulsa,
    output logic [5:0] SegundosPulsa,
    output logic       load_time
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic mode_p, up_p, down_p;

    btn_cond #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLD_CYC(HOLD_CYC),
        .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b0)
    ) u_mode (.clk(clk), .rst_n(rst_n), .btn_raw(btn_mode), .pulse(mode_p));

    btn_cond #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLD_CYC(HOLD_CYC),
        .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b1)
    ) u_up (.clk(clk), .rst_n(rst_n), .btn_raw(btn_up), .pulse(up_p));

    btn_cond #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC), .HOLD_CYC(HOLD_CYC),
        .REPEAT_CYC(REPEAT_CYC), .REPEAT_EN(1'b1)
    ) u_down (.clk(clk), .rst_n(rst_n), .btn_raw(btn_down), .pulse(down_p));

    edit_state_t      state, state_n;
    logic [5:0]       min_n, seg_n;
    logic             set_n, fsel_n, load_n;
    logic [TMO_W-1:0] tmo_cnt, tmo_n;
    logic             any_p, step_up, step_dn;

    assign any_p   = mode_p | up_p | down_p;
    assign step_up = up_p & ~down_p;
    assign step_dn = down_p & ~up_p;

    // State, edited values, registered outputs and timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            MinutosPulsa  <= 6'd0;
            SegundosPulsa <= 6'd0;
            setTime       <= 1'b0;
            field_sel     <= 1'b0;
            load_time     <= 1'b0;
            tmo_cnt       <= '0;
        end else begin
            state         <= state_n;
            MinutosPulsa  <= min_n;
            SegundosPulsa <= seg_n;
            setTime       <= set_n;
            field_sel     <= fsel_n;
            load_time     <= load_n;
            tmo_cnt       <= tmo_n;
        end
    end

    // Next state, field arithmetic and timeout; mode outranks up/down in the same cycle
    always_comb begin
        state_n = state;
        min_n   = MinutosPulsa;
        seg_n   = SegundosPulsa;
        load_n  = 1'b0;
        tmo_n   = tmo_cnt;

        case (state)
            IDLE: begin
                tmo_n = '0;
                if (mode_p) begin
                    state_n = EDIT_MIN;
                    min_n   = (Minutos  > MAX_VAL) ? MAX_VAL : Minutos;
                    seg_n   = (Segundos > MAX_VAL) ? MAX_VAL : Segundos;
                end
            end
            EDIT_MIN, EDIT_SEG: begin
                if (any_p) begin
                    tmo_n = '0;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_n   = '0;
                    state_n = IDLE;
                end else begin
                    tmo_n = tmo_cnt + 1'b1;
                end

                if (mode_p) begin
                    if (state == EDIT_MIN) begin
                        state_n = EDIT_SEG;
                    end else begin
                        state_n = IDLE;
                        load_n  = 1'b1;
                    end
                end else if (step_up || step_dn) begin
                    if (state == EDIT_MIN) begin
                        min_n = step_mod60(MinutosPulsa, step_up);
                    end else begin
                        seg_n = step_mod60(SegundosPulsa, step_up);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                tmo_n   = '0;
            end
        endcase

        set_n  = (state_n == EDIT_MIN) || (state_n == EDIT_SEG);
        fsel_n = (state_n == EDIT_SEG);
    end

endmodule
